adbg_ahb3_sram_slave: RTL and testbench
=======================================

# adbg_ahb3_sram_slave

AHB3-Lite slave with a word-organised on-chip SRAM, configurable wait states and a full two-cycle ERROR response. It is the responder for the debug unit's AHB3-Lite master port. It serves as the target for debug burst reads and writes, both in system integration and in verification benches. It exercises every AHB response path the debug master must handle: OKAY, wait-stated OKAY and ERROR.

## Interface
Parameters:
- HADDR_SIZE, 32, address width
- HDATA_SIZE, 32, data width; only 32 is supported
- MEM_DEPTH, 256, number of 32-bit words; must be a power of 2
- WAIT_STATES, 0, stall cycles inserted in every OKAY data phase (0..15)

Ports (one clock; reset is asynchronous and active-low):
- HCLK  in  1  clock, rising edge
- HRESETn  in  1  asynchronous active-low reset
- HSEL  in  1  slave select
- HADDR  in  HADDR_SIZE  address
- HWDATA  in  HDATA_SIZE  write data, valid in the data phase
- HRDATA  out  HDATA_SIZE  read data
- HWRITE  in  1  1 = write
- HSIZE  in  3  transfer size
- HBURST  in  3  burst type; ignored, every beat is decoded independently
- HPROT  in  4  protection; used only with the configuration macro
- HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ
- HMASTLOCK  in  1  ignored
- HREADY  in  1  bus ready, from the interconnect
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR

## Operation
- Accept a transfer when HSEL & HREADY & HTRANS[1] all hold. On acceptance, latch the address, HSIZE and HWRITE, and decide the error condition.
- IDLE or BUSY with HSEL high: zero-wait OKAY, no memory access.
- The transfer is an error if any of these hold:
  - HSIZE > HSIZE32
  - address misaligned to HSIZE
  - HADDR >= MEM_DEPTH*4
- Byte lanes are little-endian.
  - Byte access: lane HADDR[1:0].
  - Halfword access: lanes {HADDR[1],1} and {HADDR[1],0}.
  - Word access: all lanes.
- FSM states:
  - IDLE: no data phase pending.
  - WAIT: stall counter running.
  - DATA: final OKAY cycle.
  - ERR1, ERR2: the two ERROR cycles.
- Transitions on an accepted transfer (taken from IDLE, DATA or ERR2):
  - error → ERR1
  - otherwise, WAIT_STATES > 0 → WAIT with counter = WAIT_STATES
  - otherwise → DATA
- WAIT: decrement the counter; on reaching 1, go to DATA.
- DATA or ERR2 with no new acceptance → IDLE.
- ERR1 → ERR2 unconditionally.
- Outputs per state:
  - IDLE and DATA: HREADYOUT=1, HRESP=0.
  - WAIT: HREADYOUT=0, HRESP=0.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- Write commit: at the rising edge that ends DATA of a write, store HWDATA into the enabled lanes only.
- Read data: in DATA of a read, HRDATA = mem[latched word index]. Otherwise HRDATA = 0.
- Errored transfers never modify memory.
- Memory contents are not reset and are undefined after power-up.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, FSM in IDLE.
- Reset asserted mid-transfer forces IDLE immediately and asynchronously. A pending write is dropped.
- OKAY latency: the data phase lasts WAIT_STATES+1 cycles after the address phase.
- Back-to-back pipelining: a new address phase may overlap the DATA cycle of the previous transfer.
- A read that directly follows a write to the same word returns the new data. The write commits at the edge that opens the read's data phase, so no forwarding is needed.
- During WAIT and ERR1, HREADY is low, so no new address is accepted.
- An address phase presented in the ERR2 cycle is accepted normally. Masters that cancel by driving IDLE are also handled.

## Configuration
- ADBG_AHB3_SRAM_PROT_EN defined:
  - A write with HPROT[1]=0 (user access) is an error, taking the ERR1/ERR2 path with memory unchanged.
  - User reads are still allowed.
- ADBG_AHB3_SRAM_PROT_EN undefined: HPROT is ignored entirely.

## Test plan
- WAIT_STATES=0, MEM_DEPTH=256:
  - NONSEQ word write 0xDEADBEEF to 0x10, then read 0x10 → HRDATA=0xDEADBEEF.
  - HREADYOUT stays 1 throughout; HRESP=0.
- Byte write 0xA5 to 0x11, then word read 0x10 → 0xDEADA5EF.
- Halfword write to 0x13 (misaligned):
  - ERR1 gives HREADYOUT=0/HRESP=1, then ERR2 gives 1/1.
  - A follow-up read of 0x10 is unchanged.
- Word read from 0x400 with MEM_DEPTH=256 → two-cycle ERROR, HRDATA=0.
- WAIT_STATES=2:
  - 4-beat INCR4 read burst → each beat shows HREADYOUT low for exactly 2 cycles, then valid data.
  - Assert HRESETn low during a WAIT cycle → HREADYOUT=1 and HRESP=0 immediately; the write is not committed.
- With ADBG_AHB3_SRAM_PROT_EN:
  - Write with HPROT=4'b0001 → ERROR, memory unchanged.
  - Same write with HPROT=4'b0011 → OKAY and committed.
  - Without the macro, both writes → OKAY.

Source files
------------

// File: rtl/adbg_ahb3_sram_slave.sv
// AHB3-Lite slave over a word-organised SRAM with programmable wait states and a two-cycle ERROR.
// Build option ADBG_AHB3_SRAM_PROT_EN: user-mode writes (HPROT[1]=0) are answered with ERROR.
module adbg_ahb3_sram_slave #(
    parameter int unsigned HADDR_SIZE  = 32,
    parameter int unsigned HDATA_SIZE  = 32,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HMASTLOCK,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned AW1   = HADDR_SIZE + 1;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned LANES = HDATA_SIZE / 8;

    localparam logic [AW1-1:0]   MEM_BYTES = AW1'(MEM_DEPTH) << 2;
    localparam logic [CNT_W-1:0] WS_CNT    = CNT_W'(WAIT_STATES);
    localparam logic [2:0]       SIZE_BYTE = 3'b000;
    localparam logic [2:0]       SIZE_HALF = 3'b001;
    localparam logic [2:0]       SIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic [IDX_W-1:0] idx_q;
    logic             wr_q;
    logic [LANES-1:0] mask_q;

    logic             accept;
    logic             xfer_err;
    logic             prot_err;
    logic [LANES-1:0] lane_mask;

    logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

    logic unused;
    assign unused = ^{HBURST, HMASTLOCK, HTRANS[0], HPROT};

    // New address phases are only taken when this slave is not stalling the bus.
    assign accept = HSEL & HREADY & HTRANS[1] & (state != ST_WAIT) & (state != ST_ERR1);

`ifdef ADBG_AHB3_SRAM_PROT_EN
    assign prot_err = HWRITE & ~HPROT[1];
`else
    assign prot_err = 1'b0;
`endif

    // Address-phase decode: error classification and little-endian lane enables.
    always_comb begin
        logic align_err;
        align_err = 1'b0;
        lane_mask = LANES'(4'b1111);
        case (HSIZE)
            SIZE_BYTE: lane_mask = LANES'(4'b0001) << HADDR[1:0];
            SIZE_HALF: begin
                align_err = HADDR[0];
                lane_mask = HADDR[1] ? LANES'(4'b1100) : LANES'(4'b0011);
            end
            SIZE_WORD: align_err = |HADDR[1:0];
            default:   align_err = 1'b0;
        endcase
        xfer_err = (HSIZE > SIZE_WORD) | align_err | ({1'b0, HADDR} >= MEM_BYTES) | prot_err;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin : state_reg
        if (!HRESETn) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin : next_state
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_WAIT: begin
                if (cnt == CNT_W'(1)) state_nxt = ST_DATA;
                else                  cnt_nxt   = cnt - CNT_W'(1);
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: begin
                if (!accept) begin
                    state_nxt = ST_IDLE;
                end else if (xfer_err) begin
                    state_nxt = ST_ERR1;
                end else if (WAIT_STATES != 0) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = WS_CNT;
                end else begin
                    state_nxt = ST_DATA;
                end
            end
        endcase
    end

    always_comb begin : outputs
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = '0;
        case (state)
            ST_WAIT: HREADYOUT = 1'b0;
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            ST_ERR2: HRESP = 1'b1;
            ST_DATA: if (!wr_q) HRDATA = mem[idx_q];
            default: HRESP = 1'b0;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin : addr_latch
        if (!HRESETn) begin
            idx_q  <= '0;
            wr_q   <= 1'b0;
            mask_q <= '0;
        end else if (accept) begin
            idx_q  <= HADDR[IDX_W+1:2];
            wr_q   <= HWRITE;
            mask_q <= lane_mask;
        end
    end

    // Write commits on the edge closing DATA, so a following read sees it without forwarding.
    always_ff @(posedge HCLK) begin : mem_write
        if (state == ST_DATA && wr_q) begin
            for (int b = 0; b < int'(LANES); b++) begin
                if (mask_q[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_adbg_ahb3_sram_slave.sv
// Scoreboard bench for adbg_ahb3_sram_slave: reference memory model feeds expected
// responses into a queue; a bus monitor checks each completed data phase.
module tb_adbg_ahb3_sram_slave;

    localparam int unsigned WS    = 2;
    localparam int unsigned DEPTH = 256;
    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;

    logic        HCLK;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;

    // Single-slave interconnect: bus ready is the slave's own ready.
    assign HREADY = HREADYOUT;

    adbg_ahb3_sram_slave #(
        .HADDR_SIZE (32),
        .HDATA_SIZE (32),
        .MEM_DEPTH  (DEPTH),
        .WAIT_STATES(WS)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .HSEL     (HSEL),
        .HADDR    (HADDR),
        .HWDATA   (HWDATA),
        .HRDATA   (HRDATA),
        .HWRITE   (HWRITE),
        .HSIZE    (HSIZE),
        .HBURST   (HBURST),
        .HPROT    (HPROT),
        .HTRANS   (HTRANS),
        .HMASTLOCK(HMASTLOCK),
        .HREADY   (HREADY),
        .HREADYOUT(HREADYOUT),
        .HRESP    (HRESP)
    );

    typedef struct {
        bit          err;
        bit          wr;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [DEPTH];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] last_rdata = '0;

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, want, $time);
        end
    endtask

    task automatic finish_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    function automatic bit model_err(input logic [31:0] a, input bit wr, input logic [2:0] sz,
                                     input logic [3:0] prot);
        bit e;
        e = (sz > 3'd2) || (a >= 32'(DEPTH * 4));
        if (!e && (a % (32'd1 << sz)) != 0) e = 1'b1;
`ifdef ADBG_AHB3_SRAM_PROT_EN
        if (wr && !prot[1]) e = 1'b1;
`else
        if (wr && prot[1] && !prot[1]) e = 1'b1;
`endif
        return e;
    endfunction

    // Reference behaviour at acceptance: memory effect plus the response the master should see.
    function automatic void model_accept(input logic [31:0] a, input bit wr, input logic [2:0] sz,
                                         input logic [3:0] prot, input logic [31:0] wd);
        exp_t e;
        int   w;
        int   lane;
        e.err   = model_err(a, wr, sz, prot);
        e.wr    = wr;
        e.rdata = '0;
        if (!e.err) begin
            w = int'(a >> 2);
            if (wr) begin
                for (int b = 0; b < (1 << sz); b++) begin
                    lane = int'(a % 4) + b;
                    model_mem[w][8*lane +: 8] = wd[8*lane +: 8];
                end
            end else begin
                e.rdata = model_mem[w];
            end
        end
        exp_q.push_back(e);
    endfunction

    task automatic issue(input logic [31:0] a, input bit wr, input logic [2:0] sz,
                         input logic [3:0] prot, input logic [31:0] wd, input logic [1:0] tr,
                         input logic [2:0] burst);
        int guard;
        guard     = 0;
        HSEL      = 1'b1;
        HADDR     = a;
        HWRITE    = wr;
        HSIZE     = sz;
        HPROT     = prot;
        HTRANS    = tr;
        HBURST    = burst;
        HMASTLOCK = 1'($urandom_range(0, 1));
        @(negedge HCLK);
        while (!HREADY) begin
            guard++;
            if (guard > 40) begin
                tests++;
                fails++;
                $display("FAIL hready_timeout: HREADYOUT low for %0d cycles, want <= %0d", guard, WS);
                finish_run();
            end
            @(negedge HCLK);
        end
        @(posedge HCLK);
        model_accept(a, wr, sz, prot, wd);
        #1;
        HWDATA = wr ? wd : $urandom();
    endtask

    task automatic idle_cycles(input int n, input logic [1:0] tr);
        HSEL   = 1'($urandom_range(0, 1));
        HTRANS = tr;
        HADDR  = $urandom();
        HWRITE = 1'($urandom_range(0, 1));
        HSIZE  = 3'($urandom_range(0, 2));
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic drain();
        int guard;
        guard  = 0;
        HSEL   = 1'b0;
        HTRANS = T_IDLE;
        while (exp_q.size() != 0) begin
            @(negedge HCLK);
            guard++;
            if (guard > 100) begin
                tests++;
                fails++;
                $display("FAIL drain_timeout: %0d responses outstanding, want 0", exp_q.size());
                finish_run();
            end
        end
        @(posedge HCLK);
        #1;
    endtask

    // Bus monitor: counts stall cycles of each data phase and checks the completing beat.
    bit in_data = 1'b0;
    int waits   = 0;
    int err1    = 0;
    always @(negedge HCLK) begin : monitor
        exp_t e;
        if (!HRESETn) begin
            exp_q.delete();
            in_data = 1'b0;
        end else begin
            if (in_data) begin
                if (!HREADYOUT) begin
                    if (HRESP) err1++;
                    else       waits++;
                    check("stall_hrdata", HRDATA, 32'h0);
                end else begin
                    in_data = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_response_count", 32'(exp_q.size() + 1), 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        check("hresp", 32'(HRESP), 32'(e.err));
                        if (e.err) check("err_cycles", 32'(err1 * 16 + waits), 32'd16);
                        else       check("wait_cycles", 32'(err1 * 16 + waits), 32'(WS));
                        check(e.wr ? "write_hrdata" : (e.err ? "err_hrdata" : "read_data"),
                              HRDATA, (e.err || e.wr) ? 32'h0 : e.rdata);
                        if (!e.err && !e.wr) last_rdata = HRDATA;
                    end
                end
            end else begin
                check("idle_ready_resp", {30'h0, HREADYOUT, HRESP}, 32'h2);
                check("idle_hrdata", HRDATA, 32'h0);
            end
            if (HSEL && HREADY && HTRANS[1]) begin
                in_data = 1'b1;
                waits   = 0;
                err1    = 0;
            end
        end
    end

    initial begin
        #200000;
        tests++;
        fails++;
        $display("FAIL watchdog: simulation exceeded time limit");
        finish_run();
    end

    initial begin : stim
        logic [31:0] ra;
        logic [31:0] rd;
        logic [31:0] saved;
        logic [2:0]  rs;
        logic [3:0]  rp;
        bit          rw;

        HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HWDATA = '0; HWRITE = 1'b0;
        HSIZE = 3'd0; HBURST = 3'd0; HPROT = 4'd0; HTRANS = T_IDLE; HMASTLOCK = 1'b0;
        #12;
        check("reset_hreadyout", 32'(HREADYOUT), 32'h1);
        check("reset_hresp", 32'(HRESP), 32'h0);
        check("reset_hrdata", HRDATA, 32'h0);
        @(posedge HCLK);
        #1 HRESETn = 1'b1;

        // Give every word the bench touches a defined value.
        for (int w = 0; w < 16; w++) issue(32'(w * 4), 1'b1, 3'd2, 4'h3, $urandom(), T_NSEQ, 3'd0);
        issue(32'h3FC, 1'b1, 3'd2, 4'h3, $urandom(), T_NSEQ, 3'd0);
        drain();

        // Word write/read, byte merge, misaligned halfword, out-of-range read.
        issue(32'h10, 1'b1, 3'd2, 4'h3, 32'hDEADBEEF, T_NSEQ, 3'd0);
        issue(32'h10, 1'b0, 3'd2, 4'h3, 32'h0, T_NSEQ, 3'd0);
        drain();
        check("word_readback", last_rdata, 32'hDEADBEEF);
        issue(32'h11, 1'b1, 3'd0, 4'h3, 32'h0000A500, T_NSEQ, 3'd0);
        issue(32'h10, 0, 3'd2, 4'h3, 32'h0, T_NSEQ, 3'd0);
        issue(32'h13, 1'b1, 3'd1, 4'h3, 32'h77660000, T_NSEQ, 3'd0);
        issue(32'h10, 1'b0, 3'd2, 4'h3, 32'h0, T_NSEQ, 3'd0);
        issue(32'h400, 1'b0, 3'd2, 4'h3, 32'h0, T_NSEQ, 3'd0);
        drain();
        check("byte_merge_after_err", last_rdata, 32'hDEADA5EF);

        // Protection behaviour follows the build option through the model.
        issue(32'h20, 1'b1, 3'd2, 4'b0001, 32'h11112222, T_NSEQ, 3'd0);
        issue(32'h20, 1'b0, 3'd2, 4'b0001, 32'h0, T_NSEQ, 3'd0);
        issue(32'h20, 1'b1, 3'd2, 4'b0011, 32'h33334444, T_NSEQ, 3'd0);
        issue(32'h20, 1'b0, 3'd2, 4'b0001, 32'h0, T_NSEQ, 3'd0);
        drain();
        check("priv_write_commit", last_rdata, 32'h33334444);

        // INCR4 read burst; each beat must stall exactly WS cycles.
        for (int b = 0; b < 4; b++)
            issue(32'(32'h30 + b * 4), 1'b0, 3'd2, 4'h3, 32'h0, (b == 0) ? T_NSEQ : T_SEQ, 3'b011);
        drain();

        // Reset during a write's wait state: outputs drop to idle at once, write is lost.
        saved = model_mem[5];
        issue(32'h14, 1'b1, 3'd2, 4'h3, ~saved, T_NSEQ, 3'd0);
        HSEL = 1'b0;
        HTRANS = T_IDLE;
        #2 HRESETn = 1'b0;
        #1;
        check("async_reset_hreadyout", 32'(HREADYOUT), 32'h1);
        check("async_reset_hresp", 32'(HRESP), 32'h0);
        check("async_reset_hrdata", HRDATA, 32'h0);
        model_mem[5] = saved;
        @(negedge HCLK);
        @(posedge HCLK);
        #1 HRESETn = 1'b1;
        issue(32'h14, 1'b0, 3'd2, 4'h3, 32'h0, T_NSEQ, 3'd0);
        drain();
        check("reset_dropped_write", last_rdata, saved);

        // Randomised traffic: mixed sizes, alignments, ranges, protections and idle gaps.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 11))
                0:       ra = 32'h400 + 32'($urandom_range(0, 63));
                1:       ra = 32'h8000_0000 | 32'($urandom_range(0, 255));
                2:       ra = 32'h3FC + 32'($urandom_range(0, 3));
                default: ra = 32'($urandom_range(0, 63));
            endcase
            rs = 3'($urandom_range(0, 4));
            if (rs == 3'd4) rs = 3'd2;
            rw = 1'($urandom_range(0, 1));
            rp = 4'($urandom_range(0, 15));
            rd = $urandom();
            issue(ra, rw, rs, rp, rd, 2'($urandom_range(2, 3)), 3'd0);
            if ($urandom_range(0, 3) == 0)
                idle_cycles($urandom_range(1, 2), ($urandom_range(0, 1) == 0) ? T_IDLE : T_BUSY);
        end
        drain();
        finish_run();
    end

endmodule
